// File: rtl/axi_burst_master_pkg.sv
// Shared AXI4 constants and the burst master state encoding.
package axi_burst_master_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam int BOUNDARY_4K = 4096;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_XFER = 3'd1,
        S_W_RESP = 3'd2,
        S_R_ADDR = 3'd3,
        S_R_DATA = 3'd4
    } state_t;

endpackage

// File: rtl/axi_burst_master_strb_gen.sv
// Write-strobe generator: marks the 1<<size byte lanes starting at the beat's lane offset.
module axi_burst_strb_gen #(
    parameter int DATA_W = 64
) (
    input  logic [2:0]                     size,
    input  logic [$clog2(DATA_W/8)-1:0]    lane,
    output logic [DATA_W/8-1:0]            strb
);

    localparam int STRB_W = DATA_W / 8;

    always_comb begin
        strb = '0;
        for (int i = 0; i < STRB_W; i++) begin
            if ((i >= int'(lane)) && (i < int'(lane) + (1 << int'(size)))) begin
                strb[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst master (1..MAX_BEATS beats) with client request and beat streams.
// Optional watchdog enabled by defining AXI_BURST_MASTER_TIMEOUT_EN.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int MAX_BEATS      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_rw,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [7:0]            i_req_len,
    input  logic [2:0]            i_req_size,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic                  i_wdata_valid,
    output logic                  o_wdata_ready,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_rdata_valid,
    output logic                  o_rdata_last,
    input  logic                  i_rdata_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_invalid,
    output logic                  o_timeout,
    output logic                  m_axi_awvalid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    input  logic                  m_axi_awready,
    output logic                  m_axi_wvalid,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    input  logic                  m_axi_wready,
    input  logic                  m_axi_bvalid,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_bready,
    output logic                  m_axi_arvalid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    output logic                  m_axi_rready,
    output logic [2:0]            o_state
);

    localparam int LANE_W = $clog2(DATA_W / 8);

    // Every handshake on every channel is valid && ready sampled at the rising clock edge;
    // a valid, once raised by this block, is held until its ready is seen.

    state_t              state;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          len_r;
    logic [2:0]          size_r;
    logic [LANE_W-1:0]   beat_lane;
    logic [8:0]          beat_cnt;
    logic                aw_valid_r, aw_done, ar_valid_r;
    logic                r_err, r_dec;
    logic                done_r, error_r, invalid_r;

    logic [16:0]         req_bytes, span_end;
    logic                req_bad;
    logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                w_open, w_last, aw_fin, w_fin;

    // Accept-time legality: beat size, alignment, burst length and 4 KB crossing.
    always_comb begin
        req_bytes = (17'(i_req_len) + 17'd1) << i_req_size;
        span_end  = 17'(i_req_addr[11:0]) + req_bytes;
        req_bad   = (i_req_size > 3'(LANE_W))
                 || ((i_req_addr[7:0] & ((8'd1 << i_req_size) - 8'd1)) != 8'd0)
                 || ({1'b0, i_req_len} >= 9'(MAX_BEATS))
                 || (span_end > 17'(BOUNDARY_4K));
    end

    assign w_open = (state == S_W_XFER) && (beat_cnt <= {1'b0, len_r});
    assign w_last = (beat_cnt == {1'b0, len_r});

    assign m_axi_wvalid  = w_open && i_wdata_valid;
    assign o_wdata_ready = w_open && m_axi_wready;
    assign m_axi_wdata   = i_wdata;
    assign m_axi_wlast   = w_open && w_last;

    assign m_axi_bready  = (state == S_W_RESP);

    assign m_axi_rready  = (state == S_R_DATA) && i_rdata_ready;
    assign o_rdata_valid = (state == S_R_DATA) && m_axi_rvalid;
    assign o_rdata_last  = (state == S_R_DATA) && m_axi_rlast;
    assign o_rdata       = m_axi_rdata;

    assign aw_hs = aw_valid_r && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign b_hs  = m_axi_bready && m_axi_bvalid;
    assign ar_hs = ar_valid_r && m_axi_arready;
    assign r_hs  = m_axi_rready && m_axi_rvalid;

    assign aw_fin = aw_done || aw_hs;
    assign w_fin  = !w_open || (w_hs && w_last);

    assign m_axi_awvalid = aw_valid_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awlen   = len_r;
    assign m_axi_awsize  = size_r;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_arvalid = ar_valid_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_arlen   = len_r;
    assign m_axi_arsize  = size_r;
    assign m_axi_arburst = BURST_INCR;

    assign o_req_ready = (state == S_IDLE);
    assign o_busy      = (state != S_IDLE);
    assign o_done      = done_r;
    assign o_error     = error_r;
    assign o_invalid   = invalid_r;
    assign o_state     = state;

    axi_burst_strb_gen #(.DATA_W(DATA_W)) u_strb_gen (
        .size (size_r),
        .lane (beat_lane),
        .strb (m_axi_wstrb)
    );

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            any_hs, to_fire, timeout_r;

    assign any_hs    = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign to_fire   = o_busy && !any_hs && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign o_timeout = timeout_r;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt <= '0;
        end else if (!o_busy || any_hs || to_fire) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            addr_r     <= '0;
            len_r      <= '0;
            size_r     <= '0;
            beat_lane  <= '0;
            beat_cnt   <= '0;
            aw_valid_r <= 1'b0;
            aw_done    <= 1'b0;
            ar_valid_r <= 1'b0;
            r_err      <= 1'b0;
            r_dec      <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            invalid_r  <= 1'b0;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
            timeout_r  <= 1'b0;
`endif
        end else begin
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            invalid_r <= 1'b0;
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        addr_r    <= i_req_addr;
                        len_r     <= i_req_len;
                        size_r    <= i_req_size;
                        beat_lane <= i_req_addr[LANE_W-1:0];
                        beat_cnt  <= '0;
                        aw_done   <= 1'b0;
                        r_err     <= 1'b0;
                        r_dec     <= 1'b0;
                        if (req_bad) begin
                            done_r    <= 1'b1;
                            invalid_r <= 1'b1;
                        end else if (i_req_rw) begin
                            aw_valid_r <= 1'b1;
                            state      <= S_W_XFER;
                        end else begin
                            ar_valid_r <= 1'b1;
                            state      <= S_R_ADDR;
                        end
                    end
                end
                S_W_XFER: begin
                    if (aw_hs) begin
                        aw_valid_r <= 1'b0;
                        aw_done    <= 1'b1;
                    end
                    if (w_hs) begin
                        beat_cnt  <= beat_cnt + 9'd1;
                        beat_lane <= beat_lane + LANE_W'(32'(1) << size_r);
                    end
                    if (aw_fin && w_fin) begin
                        state <= S_W_RESP;
                    end
                end
                S_W_RESP: begin
                    if (m_axi_bvalid) begin
                        done_r    <= 1'b1;
                        error_r   <= (m_axi_bresp != RESP_OKAY);
                        invalid_r <= (m_axi_bresp == RESP_DECERR);
                        state     <= S_IDLE;
                    end
                end
                S_R_ADDR: begin
                    if (ar_hs) begin
                        ar_valid_r <= 1'b0;
                        state      <= S_R_DATA;
                    end
                end
                S_R_DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        r_err    <= r_err || (m_axi_rresp != RESP_OKAY);
                        r_dec    <= r_dec || (m_axi_rresp == RESP_DECERR);
                        if (m_axi_rlast) begin
                            // A short burst (rlast before len) still completes, flagged as error.
                            done_r    <= 1'b1;
                            error_r   <= r_err || (m_axi_rresp != RESP_OKAY)
                                      || (beat_cnt != {1'b0, len_r});
                            invalid_r <= r_dec || (m_axi_rresp == RESP_DECERR);
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
            if (to_fire) begin
                state      <= S_IDLE;
                aw_valid_r <= 1'b0;
                ar_valid_r <= 1'b0;
                done_r     <= 1'b1;
                error_r    <= 1'b1;
                invalid_r  <= 1'b0;
                timeout_r  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master (DATA_W=64, ADDR_W=32, MAX_BEATS=16).
module tb_axi_burst_master;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid, i_req_rw;
    logic [31:0] i_req_addr;
    logic [7:0]  i_req_len;
    logic [2:0]  i_req_size;
    logic [63:0] i_wdata;
    logic        i_wdata_valid, i_rdata_ready;
    logic        o_req_ready, o_wdata_ready, o_rdata_valid, o_rdata_last;
    logic [63:0] o_rdata;
    logic        o_busy, o_done, o_error, o_invalid, o_timeout;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst;
    logic        m_axi_wvalid, m_axi_wlast, m_axi_wready;
    logic [63:0] m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rlast, m_axi_rready;
    logic [2:0]  o_state;

    int checks = 0;
    int errors = 0;

    axi_burst_master #(
        .ADDR_W(32), .DATA_W(64), .MAX_BEATS(16), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_rw(i_req_rw),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len), .i_req_size(i_req_size),
        .i_wdata(i_wdata), .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready),
        .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_rdata_last(o_rdata_last),
        .i_rdata_ready(i_rdata_ready),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_invalid(o_invalid),
        .o_timeout(o_timeout),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awready(m_axi_awready),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
        .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_req_rw = 1'b0; i_req_addr = '0; i_req_len = '0; i_req_size = '0;
        i_wdata = '0; i_wdata_valid = 1'b0; i_rdata_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
        m_axi_rlast = 1'b0;
    endtask

    // Present one request for a single edge; returns at the negedge after acceptance.
    task automatic send_req(input logic rw, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size);
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_rw = rw; i_req_addr = addr; i_req_len = len; i_req_size = size;
        @(negedge i_clk);
        i_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge i_clk);
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
        checks++; if (m_axi_awvalid !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_wvalid !== 1'b0) begin
            errors++; $display("FAIL reset_valids: got aw=%b ar=%b w=%b want 0", m_axi_awvalid, m_axi_arvalid, m_axi_wvalid); end
        checks++; if (o_done !== 1'b0 || o_error !== 1'b0 || o_invalid !== 1'b0 || o_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got %b%b%b%b want 0000", o_done, o_error, o_invalid, o_timeout); end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++; if (o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_ready_busy: got ready=%b busy=%b want 1 0", o_req_ready, o_busy); end
    endtask

    task automatic test_write_burst();
        send_req(1'b1, 32'h1000, 8'd3, 3'd3);
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; i_wdata_valid = 1'b1;
        #1;
        checks++; if (m_axi_awaddr !== 32'h1000 || m_axi_awlen !== 8'd3 || m_axi_awsize !== 3'd3 || m_axi_awburst !== 2'b01) begin
            errors++; $display("FAIL wr_aw_fields: got %h %0d %0d %0d want 1000 3 3 1", m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst); end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge i_clk);
            i_wdata = 64'hA5A5_0000_0000_0000 | 64'(b);
            #1;
            checks++; if (m_axi_awvalid !== (b == 0)) begin
                errors++; $display("FAIL wr_awvalid_beat%0d: got %b want %b", b, m_axi_awvalid, (b == 0)); end
            checks++; if (m_axi_wvalid !== 1'b1 || o_wdata_ready !== 1'b1 || m_axi_wdata !== i_wdata) begin
                errors++; $display("FAIL wr_w_beat%0d: got v=%b r=%b d=%h want 1 1 %h", b, m_axi_wvalid, o_wdata_ready, m_axi_wdata, i_wdata); end
            checks++; if (m_axi_wstrb !== 8'hFF || m_axi_wlast !== (b == 3)) begin
                errors++; $display("FAIL wr_strb_last_beat%0d: got %h %b want ff %b", b, m_axi_wstrb, m_axi_wlast, (b == 3)); end
        end
        @(negedge i_clk);
        #1;
        checks++; if (o_state !== 3'd2 || m_axi_bready !== 1'b1 || m_axi_wvalid !== 1'b0) begin
            errors++; $display("FAIL wr_resp_state: got st=%0d bready=%b wvalid=%b want 2 1 0", o_state, m_axi_bready, m_axi_wvalid); end
        i_wdata_valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        @(negedge i_clk);
        m_axi_bvalid = 1'b0;
        #1;
        checks++; if (o_done !== 1'b1 || o_error !== 1'b0 || o_invalid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL wr_done: got d=%b e=%b i=%b busy=%b want 1 0 0 0", o_done, o_error, o_invalid, o_busy); end
        @(negedge i_clk);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %b want 0", o_done); end
    endtask

    task automatic test_narrow_write();
        logic [7:0] exp_strb [2];
        exp_strb[0] = 8'h08; exp_strb[1] = 8'h10;
        send_req(1'b1, 32'h2003, 8'd1, 3'd0);
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; i_wdata_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            if (b > 0) @(negedge i_clk);
            i_wdata = 64'h0000_0000_FF00_0000 << (8 * b);
            #1;
            checks++; if (m_axi_wstrb !== exp_strb[b] || m_axi_wlast !== (b == 1)) begin
                errors++; $display("FAIL narrow_strb_beat%0d: got %h %b want %h %b", b, m_axi_wstrb, m_axi_wlast, exp_strb[b], (b == 1)); end
        end
        @(negedge i_clk);
        i_wdata_valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        @(negedge i_clk);
        m_axi_bvalid = 1'b0;
        #1;
        checks++; if (o_done !== 1'b1 || o_error !== 1'b0) begin
            errors++; $display("FAIL narrow_done: got d=%b e=%b want 1 0", o_done, o_error); end
    endtask

    // AW lags W here, and the slave answers SLVERR.
    task automatic test_write_late_aw_slverr();
        send_req(1'b1, 32'h4004, 8'd0, 3'd2);
        m_axi_wready = 1'b1; i_wdata_valid = 1'b1; i_wdata = 64'h1234_5678_0000_0000;
        #1;
        checks++; if (m_axi_wstrb !== 8'hF0 || m_axi_wlast !== 1'b1 || m_axi_wvalid !== 1'b1) begin
            errors++; $display("FAIL late_aw_strb: got %h %b %b want f0 1 1", m_axi_wstrb, m_axi_wlast, m_axi_wvalid); end
        @(negedge i_clk);
        #1;
        checks++; if (o_state !== 3'd1 || m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b0 || o_wdata_ready !== 1'b0) begin
            errors++; $display("FAIL late_aw_hold: got st=%0d aw=%b wv=%b wr=%b want 1 1 0 0", o_state, m_axi_awvalid, m_axi_wvalid, o_wdata_ready); end
        i_wdata_valid = 1'b0; m_axi_wready = 1'b0; m_axi_awready = 1'b1;
        @(negedge i_clk);
        m_axi_awready = 1'b0;
        #1;
        checks++; if (o_state !== 3'd2 || m_axi_awvalid !== 1'b0) begin
            errors++; $display("FAIL late_aw_resp: got st=%0d aw=%b want 2 0", o_state, m_axi_awvalid); end
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
        @(negedge i_clk);
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        #1;
        checks++; if (o_done !== 1'b1 || o_error !== 1'b1 || o_invalid !== 1'b0) begin
            errors++; $display("FAIL late_aw_slverr: got d=%b e=%b i=%b want 1 1 0", o_done, o_error, o_invalid); end
    endtask

    task automatic test_invalid_requests();
        logic [31:0] addrs [4];
        logic [7:0]  lens  [4];
        logic [2:0]  sizes [4];
        addrs[0] = 32'h0FF8; lens[0] = 8'd1;  sizes[0] = 3'd3;
        addrs[1] = 32'h1004; lens[1] = 8'd0;  sizes[1] = 3'd3;
        addrs[2] = 32'h1000; lens[2] = 8'd16; sizes[2] = 3'd3;
        addrs[3] = 32'h1000; lens[3] = 8'd0;  sizes[3] = 3'd4;
        for (int v = 0; v < 4; v++) begin
            send_req(1'b1, addrs[v], lens[v], sizes[v]);
            #1;
            checks++; if (o_done !== 1'b1 || o_invalid !== 1'b1 || o_error !== 1'b0) begin
                errors++; $display("FAIL invalid%0d_pulse: got d=%b i=%b e=%b want 1 1 0", v, o_done, o_invalid, o_error); end
            checks++; if (m_axi_awvalid !== 1'b0 || o_busy !== 1'b0) begin
                errors++; $display("FAIL invalid%0d_no_axi: got aw=%b busy=%b want 0 0", v, m_axi_awvalid, o_busy); end
            @(negedge i_clk);
            checks++; if (o_done !== 1'b0 || o_invalid !== 1'b0 || m_axi_awvalid !== 1'b0) begin
                errors++; $display("FAIL invalid%0d_after: got d=%b i=%b aw=%b want 0 0 0", v, o_done, o_invalid, m_axi_awvalid); end
        end
    endtask

    // Burst ending exactly on a 4 KB boundary is legal; then reset aborts it.
    task automatic test_boundary_and_reset();
        send_req(1'b0, 32'h0F80, 8'd15, 3'd3);
        #1;
        checks++; if (o_invalid !== 1'b0 || o_done !== 1'b0 || m_axi_arvalid !== 1'b1 || m_axi_arlen !== 8'd15) begin
            errors++; $display("FAIL boundary_ok: got i=%b d=%b ar=%b len=%0d want 0 0 1 15", o_invalid, o_done, m_axi_arvalid, m_axi_arlen); end
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_state !== 3'd0 || m_axi_arvalid !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset: got st=%0d ar=%b busy=%b rdy=%b want 0 0 0 1", o_state, m_axi_arvalid, o_busy, o_req_ready); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_read_burst();
        logic [63:0] exp_q [$];
        logic [63:0] exp_d;
        int sidx, cyc;
        logic rv, hold;
        send_req(1'b0, 32'h3000, 8'd7, 3'd3);
        #1;
        checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h3000 || m_axi_arlen !== 8'd7 || m_axi_arburst !== 2'b01) begin
            errors++; $display("FAIL rd_ar: got v=%b a=%h l=%0d b=%0d want 1 3000 7 1", m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arburst); end
        @(negedge i_clk);
        #1;
        checks++; if (m_axi_arvalid !== 1'b1 || o_state !== 3'd3) begin
            errors++; $display("FAIL rd_ar_hold: got v=%b st=%0d want 1 3", m_axi_arvalid, o_state); end
        m_axi_arready = 1'b1;
        @(negedge i_clk);
        m_axi_arready = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(64'hD0D0_0000_0000_0000 | 64'(i));
        sidx = 0; cyc = 0; hold = 1'b0;
        while (sidx < 8 && cyc < 40) begin
            rv = hold || (cyc % 3 != 2);
            m_axi_rvalid = rv;
            m_axi_rdata  = 64'hD0D0_0000_0000_0000 | 64'(sidx);
            m_axi_rlast  = (sidx == 7);
            m_axi_rresp  = 2'b00;
            i_rdata_ready = !(cyc == 3 || cyc == 4);
            #1;
            checks++; if (o_rdata_valid !== rv || m_axi_rready !== i_rdata_ready) begin
                errors++; $display("FAIL rd_pass_cyc%0d: got v=%b rr=%b want %b %b", cyc, o_rdata_valid, m_axi_rready, rv, i_rdata_ready); end
            if (rv && i_rdata_ready) begin
                exp_d = exp_q.pop_front();
                checks++; if (o_rdata !== exp_d || o_rdata_last !== (sidx == 7)) begin
                    errors++; $display("FAIL rd_beat%0d: got %h last=%b want %h %b", sidx, o_rdata, o_rdata_last, exp_d, (sidx == 7)); end
                sidx++;
                hold = 1'b0;
            end else begin
                hold = rv;
            end
            cyc++;
            @(negedge i_clk);
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; i_rdata_ready = 1'b0;
        #1;
        checks++; if (sidx != 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL rd_count: got %0d beats want 8", sidx); end
        checks++; if (o_done !== 1'b1 || o_error !== 1'b0 || o_invalid !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL rd_done: got d=%b e=%b i=%b busy=%b want 1 0 0 0", o_done, o_error, o_invalid, o_busy); end
    endtask

    // Four beats, always accepted; rresp per beat and rlast position come from the tables.
    task automatic run_read4(input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] r2,
                             input logic [1:0] r3, input int last_at);
        logic [1:0] resp [4];
        resp[0] = r0; resp[1] = r1; resp[2] = r2; resp[3] = r3;
        send_req(1'b0, 32'h5000, 8'd3, 3'd3);
        m_axi_arready = 1'b1;
        @(negedge i_clk);
        m_axi_arready = 1'b0; i_rdata_ready = 1'b1;
        for (int b = 0; b <= last_at; b++) begin
            m_axi_rvalid = 1'b1; m_axi_rresp = resp[b]; m_axi_rlast = (b == last_at);
            m_axi_rdata = 64'(b);
            @(negedge i_clk);
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; i_rdata_ready = 1'b0;
        #1;
    endtask

    task automatic test_read_errors();
        run_read4(2'b00, 2'b00, 2'b10, 2'b11, 3);
        checks++; if (o_done !== 1'b1 || o_error !== 1'b1 || o_invalid !== 1'b1) begin
            errors++; $display("FAIL rd_err_flags: got d=%b e=%b i=%b want 1 1 1", o_done, o_error, o_invalid); end
        run_read4(2'b00, 2'b00, 2'b00, 2'b00, 1);
        checks++; if (o_done !== 1'b1 || o_error !== 1'b1 || o_invalid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++; $display("FAIL rd_early_last: got d=%b e=%b i=%b rdy=%b want 1 1 0 1", o_done, o_error, o_invalid, o_req_ready); end
        run_read4(2'b00, 2'b00, 2'b00, 2'b00, 3);
        checks++; if (o_done !== 1'b1 || o_error !== 1'b0 || o_invalid !== 1'b0) begin
            errors++; $display("FAIL rd_sticky_clear: got d=%b e=%b i=%b want 1 0 0", o_done, o_error, o_invalid); end
    endtask

`ifdef AXI_BURST_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        send_req(1'b1, 32'h0000, 8'd0, 3'd3);
        n = 0;
        while (n < 40 && o_timeout !== 1'b1) begin
            @(negedge i_clk);
            n++;
        end
        #1;
        checks++; if (n != 16) begin
            errors++; $display("FAIL timeout_delay: got %0d cycles want 16", n); end
        checks++; if (o_done !== 1'b1 || o_error !== 1'b1 || o_req_ready !== 1'b1 || m_axi_awvalid !== 1'b0) begin
            errors++; $display("FAIL timeout_flags: got d=%b e=%b rdy=%b aw=%b want 1 1 1 0", o_done, o_error, o_req_ready, m_axi_awvalid); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_burst();
        test_narrow_write();
        test_write_late_aw_slverr();
        test_invalid_requests();
        test_boundary_and_reset();
        test_read_burst();
        test_read_errors();
`ifdef AXI_BURST_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
